us_arp_tx_mq: RTL
=================

Name: us_arp_tx_mq

Overview:
- Parametrised successor ARP transmitter for the 10G UDP stack. Accepts ARP commands (request, reply, gratuitous) through a small command FIFO, serialises the 28-byte ARP payload onto an AXI4-Stream master of configurable width, and optionally pads the payload to 46 bytes.
- Adds queuing, periodic gratuitous ARP, a parametrised start timeout with drop reporting, and AXIS-compliant registered outputs.
- Sits between the ARP cache/responder and the Ethernet TX mux. The MAC header (EtherType 0x0806) is added downstream.

Parameters:
- DATA_WIDTH, 64, tdata width. Legal values: 32 or 64. KEEP_W = DATA_WIDTH/8.
- CMD_FIFO_DEPTH, 4, command FIFO entries. Power of 2, minimum 2.
- TIMEOUT_CYCLES, 1000000, cycles the first beat may wait for tready before the frame is dropped.
- GARP_PERIOD, 0, cycles between automatic gratuitous ARPs. 0 disables them.
- PAD_MIN, 1, 1 pads the payload with zeros to 46 bytes; 0 sends 28 bytes.

Ports:
- tx_axis_aclk  in  1  clock.
- tx_axis_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command push strobe.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  command type: 0 = request, 1 = reply, 2 = gratuitous, 3 = ignored (consumed, nothing sent).
- cmd_ip  in  32  target IP.
- cmd_mac  in  48  target MAC. Forced to 0 for request and gratuitous.
- src_mac_addr  in  48  local MAC. Sampled at frame launch.
- src_ip_addr  in  32  local IP. Sampled at frame launch.
- arp_tx_axis_tdata  out  DATA_WIDTH  payload beat.
- arp_tx_axis_tkeep  out  KEEP_W  byte enables.
- arp_tx_axis_tvalid  out  1  beat valid.
- arp_tx_axis_tlast  out  1  last beat.
- arp_tx_axis_tready  in  1  sink ready.
- arp_not_empty  out  1  high while a command is queued or a frame is in flight.
- tx_done  out  1  one-cycle pulse when the tlast beat is accepted.
- tx_drop  out  1  one-cycle pulse on timeout abort.
- frame_cnt  out  16  frames completed. Wraps at 0xFFFF -> 0.

Behaviour:
- Reset: every output is 0, except cmd_ready = 1 (FIFO is emptied). FIFO, GARP timer, timeout counter and frame_cnt are cleared.
- A reset mid-frame aborts the frame immediately: tvalid = 0 on the next cycle, and no tlast is emitted.
- The FIFO pushes on cmd_valid & cmd_ready. A push to a full FIFO is not possible because cmd_ready = 0.
- Simultaneous push and pop on a full FIFO is allowed, and cmd_ready stays 0 that cycle.

FSM states: IDLE, LOAD, SEND, DROP.
- IDLE -> LOAD when the FIFO is not empty, or the GARP timer has expired. The FIFO has priority; an expired GARP stays pending until serviced.
- LOAD (1 cycle) does the following:
  - pops the entry;
  - latches the op code: request and gratuitous = 0x0001, reply = 0x0002;
  - builds the frame byte vector: HType 0x0001, PType 0x0800, HL 06, PL 04, op, SenderMAC, SenderIP, TargetMAC, TargetIP, then zero pad;
  - for gratuitous, TargetIP = src_ip_addr and TargetMAC = 0;
  - loads beat index 0;
  - registers tvalid = 1 for the next cycle;
  - for cmd_op = 3, returns to IDLE and sends nothing.
- SEND:
  - Byte n of the frame appears at tdata[8*(n mod KEEP_W)+7 : 8*(n mod KEEP_W)]. Byte 0 is HType MSB 0x00, byte 1 is 0x01.
  - The beat advances only on tvalid & tready.
  - tdata, tkeep and tlast stay stable while tvalid & !tready.
  - tvalid never depends combinationally on tready.
  - Last beat: tlast = 1 and tkeep = low (LEN mod KEEP_W) bits set, or all ones if the remainder is 0. LEN = 46 if PAD_MIN, else 28.
  - Beat counts for 64-bit: 4 beats with last tkeep 0x0F (PAD_MIN = 0), 6 beats with last tkeep 0x3F (PAD_MIN = 1).
  - Beat counts for 32-bit: 7 beats with last tkeep 0xF, or 12 beats with last tkeep 0x3.
  - On acceptance of the last beat: tx_done pulses, frame_cnt increments, and the next cycle goes to IDLE with tvalid = 0. There is at least one idle cycle between frames.
- Timeout:
  - The counter runs only while beat 0 is presented and not accepted.
  - When it reaches TIMEOUT_CYCLES-1 without a handshake, go to DROP: tvalid = 0, tx_drop pulses, the entry is discarded, then return to IDLE.
  - Once beat 0 is accepted, the frame always completes. There is no timeout after the first beat.
- GARP timer:
  - Counts every cycle when GARP_PERIOD > 0.
  - On reaching GARP_PERIOD-1 it sets a pending flag and wraps to 0.
  - The flag clears when the gratuitous frame enters LOAD. Multiple expiries collapse into one pending flag.
- arp_not_empty = FIFO not empty | state != IDLE | GARP pending.

Decomposition:
- Package us_arp_pkg:
  - constants ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, ARP_OP_REQUEST, ARP_OP_REPLY;
  - cmd_op encodings;
  - ARP_LEN = 28 and ARP_PAD_LEN = 46;
  - FSM state encoding.
- Sub-module us_sync_fifo: single-clock FIFO parametrised on width (82 bits: op + ip + mac) and depth, with full/empty flags and synchronous active-high reset. It is reused elsewhere in the stack.

Test Plan:
1. Request, DATA_WIDTH 64, PAD_MIN 0, src 0xAC1445FFAFC4 / 192.168.1.144, target 192.168.1.149, tready held 1 -> 4 beats:
   - beat 0 tdata = 0x0100_0406_0008_0100;
   - last beat tkeep = 0x0F, tdata[31:0] = 0x9501A8C0, tlast = 1;
   - tx_done pulses, frame_cnt = 1.
2. Reply, DATA_WIDTH 32, PAD_MIN 1 -> 12 beats, op bytes 0x00 0x02, last tkeep = 0x3 with zero data.
3. Backpressure: tready toggles 1/0 every cycle -> all beats held stable during stalls, frame identical to scenario 1.
4. Timeout: TIMEOUT_CYCLES = 16, tready held 0 -> tvalid high for 16 cycles, then tx_drop pulse, tvalid = 0, frame_cnt unchanged. The next queued command is then sent after tready rises.
5. Queue and FIFO: push 5 commands with CMD_FIFO_DEPTH = 4 while the sink is stalled -> cmd_ready = 0 after 4 entries; after release, 5 frames go out in order.
6. GARP: GARP_PERIOD = 100, no commands -> a gratuitous frame every 100 cycles with TargetIP = src_ip and TargetMAC = 0. A reset asserted mid-frame gives tvalid = 0 the next cycle, no tlast, and frame_cnt = 0.

Source files
------------

// File: rtl/us_arp_pkg.sv
// Shared ARP constants, command encodings and FSM state encoding
// for the 10G UDP stack ARP transmitter.
package us_arp_pkg;

    localparam logic [15:0] ARP_HTYPE      = 16'h0001;
    localparam logic [15:0] ARP_PTYPE      = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'h06;
    localparam logic [7:0]  ARP_PLEN       = 8'h04;
    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

    localparam logic [1:0] CMD_REQUEST    = 2'd0;
    localparam logic [1:0] CMD_REPLY      = 2'd1;
    localparam logic [1:0] CMD_GRATUITOUS = 2'd2;
    localparam logic [1:0] CMD_IGNORE     = 2'd3;

    localparam int unsigned ARP_LEN     = 28;
    localparam int unsigned ARP_PAD_LEN = 46;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    // Wire order has byte 0 as the MSB; the stream wants byte 0 in the low lane.
    function automatic logic [8*ARP_LEN-1:0] arp_byte_swap(input logic [8*ARP_LEN-1:0] be);
        logic [8*ARP_LEN-1:0] le;
        le = '0;
        for (int unsigned n = 0; n < ARP_LEN; n++) begin
            le[8*n +: 8] = be[8*(ARP_LEN-1-n) +: 8];
        end
        return le;
    endfunction

endpackage

// File: rtl/us_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and synchronous
// active-high reset; shared by several blocks of the UDP stack.
module us_sync_fifo #(
    parameter int unsigned WIDTH = 82,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/us_arp_tx_mq.sv
// Queued ARP transmitter: command FIFO, periodic gratuitous ARP, start timeout
// and registered AXI4-Stream output of the (optionally padded) ARP payload.
module us_arp_tx_mq
    import us_arp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CMD_FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned GARP_PERIOD    = 0,
    parameter int unsigned PAD_MIN        = 1
) (
    input  logic                    tx_axis_aclk,
    input  logic                    tx_axis_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [31:0]             cmd_ip,
    input  logic [47:0]             cmd_mac,
    input  logic [47:0]             src_mac_addr,
    input  logic [31:0]             src_ip_addr,
    output logic [DATA_WIDTH-1:0]   arp_tx_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] arp_tx_axis_tkeep,
    output logic                    arp_tx_axis_tvalid,
    output logic                    arp_tx_axis_tlast,
    input  logic                    arp_tx_axis_tready,
    output logic                    arp_not_empty,
    output logic                    tx_done,
    output logic                    tx_drop,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned KEEP_W     = DATA_WIDTH / 8;
    localparam int unsigned LEN        = (PAD_MIN != 0) ? ARP_PAD_LEN : ARP_LEN;
    localparam int unsigned NBEATS     = (LEN + KEEP_W - 1) / KEEP_W;
    localparam int unsigned FRAME_W    = NBEATS * DATA_WIDTH;
    localparam int unsigned BW         = $clog2(NBEATS);
    localparam int unsigned LAST_BYTES = LEN % KEEP_W;
    localparam int unsigned TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GW         = (GARP_PERIOD > 1) ? $clog2(GARP_PERIOD) : 1;

    localparam logic [KEEP_W-1:0] LAST_KEEP =
        (LAST_BYTES == 0) ? '1 : KEEP_W'((1 << LAST_BYTES) - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GARP_LAST = (GARP_PERIOD > 0) ? GW'(GARP_PERIOD - 1) : '0;
    localparam logic [BW-1:0] PRE_LAST  = BW'(NBEATS - 2);

    logic [1:0]         state;
    logic               load_garp;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rd;
    logic [81:0]        fifo_dout;
    logic [1:0]         e_op;
    logic [15:0]        op_code;
    logic [47:0]        t_mac;
    logic [31:0]        t_ip;
    logic [FRAME_W-1:0] frame_d;
    logic [FRAME_W-1:0] frame_q;
    logic [BW-1:0]      beat_idx;
    logic [TW-1:0]      to_cnt;
    logic [GW-1:0]      garp_cnt;
    logic               garp_pend;

    assign cmd_ready     = !fifo_full;
    assign fifo_rd       = (state == ST_LOAD) && !load_garp;
    assign arp_not_empty = !fifo_empty || (state != ST_IDLE) || garp_pend;

    us_sync_fifo #(
        .WIDTH (82),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (tx_axis_aclk),
        .rst     (tx_axis_areset),
        .wr_en   (cmd_valid && cmd_ready),
        .wr_data ({cmd_op, cmd_ip, cmd_mac}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        e_op    = load_garp ? CMD_GRATUITOUS : fifo_dout[81:80];
        op_code = (e_op == CMD_REPLY) ? ARP_OP_REPLY : ARP_OP_REQUEST;
        t_mac   = (e_op == CMD_REPLY) ? fifo_dout[47:0] : '0;
        t_ip    = (e_op == CMD_GRATUITOUS) ? src_ip_addr : fifo_dout[79:48];
        frame_d = '0;
        frame_d[8*ARP_LEN-1:0] = arp_byte_swap({ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, op_code,
                                                src_mac_addr, src_ip_addr, t_mac, t_ip});
    end

    always_ff @(posedge tx_axis_aclk) begin
        if (tx_axis_areset) begin
            state              <= ST_IDLE;
            load_garp          <= 1'b0;
            frame_q            <= '0;
            beat_idx           <= '0;
            to_cnt             <= '0;
            garp_cnt           <= '0;
            garp_pend          <= 1'b0;
            arp_tx_axis_tdata  <= '0;
            arp_tx_axis_tkeep  <= '0;
            arp_tx_axis_tvalid <= 1'b0;
            arp_tx_axis_tlast  <= 1'b0;
            tx_done            <= 1'b0;
            tx_drop            <= 1'b0;
            frame_cnt          <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_drop <= 1'b0;

            // Clear before the timer update so a coincident expiry stays pending.
            if (state == ST_LOAD && load_garp) begin
                garp_pend <= 1'b0;
            end
            if (GARP_PERIOD > 0) begin
                if (garp_cnt == GARP_LAST) begin
                    garp_cnt  <= '0;
                    garp_pend <= 1'b1;
                end else begin
                    garp_cnt <= garp_cnt + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        load_garp <= 1'b0;
                        state     <= ST_LOAD;
                    end else if (garp_pend) begin
                        load_garp <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!load_garp && fifo_dout[81:80] == CMD_IGNORE) begin
                        state <= ST_IDLE;
                    end else begin
                        arp_tx_axis_tdata  <= frame_d[DATA_WIDTH-1:0];
                        frame_q            <= frame_d >> DATA_WIDTH;
                        arp_tx_axis_tkeep  <= '1;
                        arp_tx_axis_tlast  <= 1'b0;
                        arp_tx_axis_tvalid <= 1'b1;
                        beat_idx           <= '0;
                        to_cnt             <= '0;
                        state              <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (arp_tx_axis_tvalid && arp_tx_axis_tready) begin
                        if (arp_tx_axis_tlast) begin
                            arp_tx_axis_tvalid <= 1'b0;
                            arp_tx_axis_tlast  <= 1'b0;
                            arp_tx_axis_tkeep  <= '0;
                            arp_tx_axis_tdata  <= '0;
                            tx_done            <= 1'b1;
                            frame_cnt          <= frame_cnt + 1'b1;
                            state              <= ST_IDLE;
                        end else begin
                            arp_tx_axis_tdata <= frame_q[DATA_WIDTH-1:0];
                            frame_q           <= frame_q >> DATA_WIDTH;
                            beat_idx          <= beat_idx + 1'b1;
                            arp_tx_axis_tlast <= (beat_idx == PRE_LAST);
                            arp_tx_axis_tkeep <= (beat_idx == PRE_LAST) ? LAST_KEEP : '1;
                        end
                    end else if (beat_idx == '0) begin
                        if (to_cnt == TO_LAST) begin
                            arp_tx_axis_tvalid <= 1'b0;
                            arp_tx_axis_tdata  <= '0;
                            arp_tx_axis_tkeep  <= '0;
                            tx_drop            <= 1'b1;
                            state              <= ST_DROP;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
